// File: rtl/conv_mem_host.sv
// Host-side memory responder for the image-convolution engine.
// Holds the 64x64 input image and the five layer result banks, loads the
// image from a stream, hands control to the engine with ready/busy, serves
// combinational image and layer reads, and streams any bank back out.
module conv_mem_host #(
  parameter int DW       = 20,
  parameter int AW       = 12,
  parameter int L0_DEPTH = 4096,
  parameter int L1_DEPTH = 1024,
  parameter int L2_DEPTH = 2048
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  input  logic          dump_start,
  input  logic [2:0]    dump_sel,
  output logic          dump_valid,
  output logic [DW-1:0] dump_data,
  output logic          dump_last,
  input  logic          dump_ready,
  output logic          done,
  output logic [7:0]    err_cnt
);

  localparam int IMG_DEPTH = 1 << AW;
  localparam int L0_AW     = $clog2(L0_DEPTH);
  localparam int L1_AW     = $clog2(L1_DEPTH);
  localparam int L2_AW     = $clog2(L2_DEPTH);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DONE,
    ST_DUMP
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ld_ptr_q, ld_ptr_d;
  logic [AW-1:0] dump_ptr_q, dump_ptr_d;
  logic [2:0]    dump_sel_q, dump_sel_d;
  logic [7:0]    err_q, err_d;

  logic          ld_we;
  logic          dump_err;
  logic          rd_ok, wr_ok;
  logic          rd_err, wr_err;
  logic [1:0]    err_inc;
  logic [8:0]    err_sum;

  logic [DW-1:0] img_mem  [IMG_DEPTH];
  logic [DW-1:0] l0k0_mem [L0_DEPTH];
  logic [DW-1:0] l0k1_mem [L0_DEPTH];
  logic [DW-1:0] l1k0_mem [L1_DEPTH];
  logic [DW-1:0] l1k1_mem [L1_DEPTH];
  logic [DW-1:0] l2_mem   [L2_DEPTH];

  // Number of words in the bank selected by sel; zero marks "no bank", so a
  // single "address < depth" test covers both select and range validity.
  function automatic logic [AW:0] bank_depth(input logic [2:0] sel);
    case (sel)
      3'd1, 3'd2: return (AW+1)'(L0_DEPTH);
      3'd3, 3'd4: return (AW+1)'(L1_DEPTH);
      3'd5:       return (AW+1)'(L2_DEPTH);
      default:    return '0;
    endcase
  endfunction

  // Combinational read of one word from the selected layer bank.
  function automatic logic [DW-1:0] bank_rd(input logic [2:0] sel, input logic [AW-1:0] addr);
    case (sel)
      3'd1:    return l0k0_mem[addr[L0_AW-1:0]];
      3'd2:    return l0k1_mem[addr[L0_AW-1:0]];
      3'd3:    return l1k0_mem[addr[L1_AW-1:0]];
      3'd4:    return l1k1_mem[addr[L1_AW-1:0]];
      3'd5:    return l2_mem[addr[L2_AW-1:0]];
      default: return '0;
    endcase
  endfunction

  // Layer access qualification; writes are refused while the image loads.
  always_comb begin
    rd_ok  = crd && ({1'b0, caddr_rd} < bank_depth(csel));
    wr_ok  = cwr && (state_q != ST_LOAD) && ({1'b0, caddr_wr} < bank_depth(csel));
    rd_err = crd && !rd_ok;
    wr_err = cwr && !wr_ok;
  end

  // Zero-latency read ports; a same-cycle write is not bypassed.
  assign idata    = img_mem[iaddr];
  assign cdata_rd = rd_ok ? bank_rd(csel, caddr_rd) : '0;

  // Next-state and output decode for the load/run/dump sequence.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    ld_ptr_d   = ld_ptr_q;
    dump_ptr_d = dump_ptr_q;
    dump_sel_d = dump_sel_q;
    ld_we      = 1'b0;
    dump_err   = 1'b0;
    ld_ready   = 1'b0;
    ready      = 1'b0;
    done       = 1'b0;
    dump_valid = 1'b0;
    dump_last  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          ld_we    = 1'b1;
          ld_ptr_d = ld_ptr_q + 1'b1;
          if (&ld_ptr_q) state_d = ST_START;
        end
      end
      ST_START: begin
        ready = 1'b1;
        if (busy) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!busy) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (dump_start) begin
          if (bank_depth(dump_sel) != '0) begin
            state_d    = ST_DUMP;
            dump_ptr_d = '0;
            dump_sel_d = dump_sel;
          end else begin
            dump_err = 1'b1;
          end
        end
      end
      ST_DUMP: begin
        dump_valid = 1'b1;
        dump_last  = ({1'b0, dump_ptr_q} == (bank_depth(dump_sel_q) - 1'b1));
        if (dump_ready) begin
          if (dump_last) state_d = ST_DONE;
          else           dump_ptr_d = dump_ptr_q + 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign dump_data = dump_valid ? bank_rd(dump_sel_q, dump_ptr_q) : '0;

  // Illegal-access counter: up to three errors per cycle, saturating at 255.
  always_comb begin
    err_inc = {1'b0, rd_err} + {1'b0, wr_err} + {1'b0, dump_err};
    err_sum = {1'b0, err_q} + {7'b0, err_inc};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  assign err_cnt = err_q;

  // Control registers with asynchronous reset back to LOAD.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= ST_LOAD;
      ld_ptr_q   <= '0;
      dump_ptr_q <= '0;
      dump_sel_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      ld_ptr_q   <= ld_ptr_d;
      dump_ptr_q <= dump_ptr_d;
      dump_sel_q <= dump_sel_d;
      err_q      <= err_d;
    end
  end

  // Image and layer bank write ports.
  always_ff @(posedge clk) begin
    // NOTE: the memories have no reset; their contents are only meaningful
    // once written, and a reset branch would stop them mapping to RAM.
    if (ld_we) img_mem[ld_ptr_q] <= ld_data;
    if (wr_ok) begin
      case (csel)
        3'd1:    l0k0_mem[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        3'd2:    l0k1_mem[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        3'd3:    l1k0_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        3'd4:    l1k1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        3'd5:    l2_mem[caddr_wr[L2_AW-1:0]]   <= cdata_wr;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mem_host.sv
// Self-checking bench for conv_mem_host: reset values, image load and read,
// ready/busy handshake, a table of layer-access corner cases, a paced bank
// dump, random layer traffic against a bank/error model, and reset mid-dump.
module tb_conv_mem_host;

  localparam int DW = 20;
  localparam int AW = 12;

  logic          clk;
  logic          reset;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;
  logic          dump_start;
  logic [2:0]    dump_sel;
  logic          dump_valid;
  logic [DW-1:0] dump_data;
  logic          dump_last;
  logic          dump_ready;
  logic          done;
  logic [7:0]    err_cnt;

  conv_mem_host #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .csel(csel),
    .dump_start(dump_start), .dump_sel(dump_sel),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_last(dump_last),
    .dump_ready(dump_ready),
    .done(done), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: bank sizes by select, contents, written flags, errors.
  int            depth_of [8] = '{0, 4096, 4096, 1024, 1024, 2048, 0, 0};
  logic [DW-1:0] img_m  [4096];
  logic [DW-1:0] bank_m [8][4096];
  bit            bank_w [8][4096];
  int            err_m = 0;

  task automatic model_read(input bit rd, input int sel, input int addr,
                            output bit known, output logic [DW-1:0] val);
    known = 1'b1;
    val   = '0;
    if (rd && addr < depth_of[sel]) begin
      known = bank_w[sel][addr];
      val   = bank_m[sel][addr];
    end
  endtask

  task automatic model_step(input bit wr, input bit rd, input int sel, input int awr,
                            input int ard, input logic [DW-1:0] d);
    int errs;
    errs = 0;
    if (wr) begin
      if (awr < depth_of[sel]) begin
        bank_m[sel][awr] = d;
        bank_w[sel][awr] = 1'b1;
      end else begin
        errs++;
      end
    end
    if (rd && !(ard < depth_of[sel])) errs++;
    err_m = (err_m + errs > 255) ? 255 : err_m + errs;
  endtask

  task automatic drive_layer(input bit wr, input bit rd, input int sel, input int awr,
                             input int ard, input logic [DW-1:0] d);
    cwr      = wr;
    crd      = rd;
    csel     = 3'(sel);
    caddr_wr = AW'(awr);
    caddr_rd = AW'(ard);
    cdata_wr = d;
  endtask

  // One random layer cycle checked against the model.
  task automatic layer_cycle(input bit wr, input bit rd, input int sel, input int awr,
                             input int ard, input logic [DW-1:0] d);
    bit            known;
    logic [DW-1:0] exp;
    drive_layer(wr, rd, sel, awr, ard, d);
    #1;
    model_read(rd, sel, ard, known, exp);
    if (known) check("rand_cdata_rd", 32'(cdata_rd), 32'(exp));
    tick();
    model_step(wr, rd, sel, awr, ard, d);
    check("rand_err_cnt", 32'(err_cnt), 32'(err_m));
  endtask

  typedef struct {
    bit            wr;
    bit            rd;
    int            sel;
    int            awr;
    int            ard;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rd;
    int            exp_err;
  } vec_t;

  vec_t vecs [17];

  initial begin
    forever begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    int  a;
    int  cyc;
    int  idx;

    // Layer-access corner cases; err is the cumulative count after the edge.
    vecs[0]  = '{1'b1, 1'b0, 3, 1023, 0,    20'hABCDE, 20'h00000, 0};
    vecs[1]  = '{1'b0, 1'b1, 3, 0,    1023, 20'h00000, 20'hABCDE, 0};
    vecs[2]  = '{1'b1, 1'b0, 3, 1024, 0,    20'h12345, 20'h00000, 1};
    vecs[3]  = '{1'b1, 1'b1, 0, 5,    5,    20'h00001, 20'h00000, 3};
    vecs[4]  = '{1'b0, 1'b1, 0, 0,    7,    20'h00000, 20'h00000, 4};
    vecs[5]  = '{1'b1, 1'b1, 7, 0,    0,    20'h00002, 20'h00000, 6};
    vecs[6]  = '{1'b1, 1'b0, 1, 4095, 0,    20'h11111, 20'h00000, 6};
    vecs[7]  = '{1'b1, 1'b1, 1, 4095, 4095, 20'h22222, 20'h11111, 6};
    vecs[8]  = '{1'b0, 1'b1, 1, 0,    4095, 20'h00000, 20'h22222, 6};
    vecs[9]  = '{1'b1, 1'b1, 5, 2048, 2048, 20'h33333, 20'h00000, 8};
    vecs[10] = '{1'b0, 1'b1, 4, 0,    1024, 20'h00000, 20'h00000, 9};
    vecs[11] = '{1'b1, 1'b0, 2, 0,    0,    20'h0FFFF, 20'h00000, 9};
    vecs[12] = '{1'b0, 1'b1, 2, 0,    0,    20'h00000, 20'h0FFFF, 9};
    vecs[13] = '{1'b1, 1'b1, 6, 10,   10,   20'h00003, 20'h00000, 11};
    vecs[14] = '{1'b0, 1'b1, 3, 0,    1023, 20'h00000, 20'hABCDE, 11};
    vecs[15] = '{1'b1, 1'b0, 4, 1023, 0,    20'h44444, 20'h00000, 11};
    vecs[16] = '{1'b0, 1'b1, 3, 0,    1023, 20'h00000, 20'hABCDE, 11};

    reset = 1'b1; ld_valid = 1'b0; ld_data = '0; busy = 1'b0; iaddr = '0;
    cwr = 1'b0; caddr_wr = '0; cdata_wr = '0; crd = 1'b0; caddr_rd = '0; csel = '0;
    dump_start = 1'b0; dump_sel = '0; dump_ready = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 0);
    check("rst_dump_valid", 32'(dump_valid), 0);
    check("rst_dump_last", 32'(dump_last), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_ld_ready", 32'(ld_ready), 1);
    reset = 1'b0;
    tick();

    // Image load img[a] = a with random gaps in ld_valid.
    a = 0;
    cyc = 0;
    while (a < 4096 && cyc < 20000) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_data  = DW'(a);
      #1;
      check("load_ld_ready", 32'(ld_ready), 1);
      check("load_ready_low", 32'(ready), 0);
      tick();
      if (ld_valid) begin
        img_m[a] = DW'(a);
        a++;
      end
      cyc++;
    end
    ld_valid = 1'b0;
    if (a < 4096) bound_fail("image_load");
    #1;
    check("ready_after_load", 32'(ready), 1);
    check("ld_ready_after_load", 32'(ld_ready), 0);

    // Image read port.
    iaddr = 12'h041;
    #1;
    check("idata_041", 32'(idata), 32'h00041);
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 4095);
      iaddr = AW'(a);
      #1;
      check("idata_rand", 32'(idata), 32'(img_m[a]));
    end

    // START held with busy low, then RUN, then DONE.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("start_ready_hold", 32'(ready), 1);
    end
    busy = 1'b1;
    tick();
    check("run_ready_low", 32'(ready), 0);
    check("run_done_low", 32'(done), 0);
    repeat (3) tick();
    busy = 1'b0;
    #1;
    check("run_done_still_low", 32'(done), 0);
    tick();
    check("done_high", 32'(done), 1);

    // Table-driven layer access corner cases.
    for (int i = 0; i < 17; i++) begin
      drive_layer(vecs[i].wr, vecs[i].rd, vecs[i].sel, vecs[i].awr, vecs[i].ard, vecs[i].d);
      #1;
      check($sformatf("vec%0d_cdata_rd", i), 32'(cdata_rd), 32'(vecs[i].exp_rd));
      tick();
      model_step(vecs[i].wr, vecs[i].rd, vecs[i].sel, vecs[i].awr, vecs[i].ard, vecs[i].d);
      check($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_err));
    end
    drive_layer(0, 0, 0, 0, 0, '0);

    // Fill bank 5 with [k] = k.
    for (int k = 0; k < 2048; k++) begin
      drive_layer(1, 0, 5, k, 0, DW'(k));
      tick();
      model_step(1, 0, 5, k, 0, DW'(k));
    end
    drive_layer(0, 0, 0, 0, 0, '0);
    #1;
    check("fill_err_cnt", 32'(err_cnt), 32'(err_m));

    // Dump bank 5 with dump_ready toggling every cycle.
    dump_sel   = 3'd5;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 2048 && cyc < 10000) begin
      dump_ready = (cyc % 2) == 1;
      #1;
      check("dump_valid", 32'(dump_valid), 1);
      check("dump_done_low", 32'(done), 0);
      check("dump_data", 32'(dump_data), 32'(bank_m[5][idx]));
      check("dump_last", 32'(dump_last), 32'(idx == 2047));
      tick();
      if (dump_ready) idx++;
      cyc++;
    end
    dump_ready = 1'b0;
    if (idx < 2048) bound_fail("dump_bank5");
    #1;
    check("dump_end_done", 32'(done), 1);
    check("dump_end_valid", 32'(dump_valid), 0);

    // Invalid dump selects are ignored and counted.
    dump_sel   = 3'd0;
    dump_start = 1'b1;
    tick();
    dump_sel   = 3'd7;
    tick();
    dump_start = 1'b0;
    err_m = (err_m + 2 > 255) ? 255 : err_m + 2;
    #1;
    check("bad_dump_done", 32'(done), 1);
    check("bad_dump_valid", 32'(dump_valid), 0);
    check("bad_dump_err_cnt", 32'(err_cnt), 32'(err_m));

    // Random layer traffic against the model; errors may saturate here.
    for (int i = 0; i < 600; i++) begin
      int sel;
      int awr;
      int ard;
      sel = $urandom_range(0, 7);
      awr = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4095);
      ard = ($urandom_range(0, 2) == 0) ? awr :
            (($urandom_range(0, 1) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4095));
      layer_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sel, awr, ard, DW'($urandom));
    end
    drive_layer(0, 0, 0, 0, 0, '0);

    // Reset in the middle of a dump.
    dump_sel   = 3'd5;
    dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    repeat (4) tick();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(ready), 0);
    check("mid_rst_dump_valid", 32'(dump_valid), 0);
    check("mid_rst_dump_last", 32'(dump_last), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_err_cnt", 32'(err_cnt), 0);
    check("mid_rst_ld_ready", 32'(ld_ready), 1);
    dump_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Fresh load restarts at address 0; address 3 keeps its old content.
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = DW'(32'h50000 + i);
      tick();
    end
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iaddr = AW'(i);
      #1;
      check("reload_idata", 32'(idata), (i < 3) ? 32'h50000 + i : 32'(img_m[3]));
    end
    check("reload_ld_ready", 32'(ld_ready), 1);
    check("reload_ready", 32'(ready), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_mem_host.md
# conv_mem_host

Host-side responder for the 2019 image-convolution engine interface. It holds the 64x64 input image and the five result memories (L0 kernel 0/1, L1 kernel 0/1, L2). It loads the image from a stream, releases the engine with `ready`, and serves `iaddr`/`idata` reads plus `crd`/`cwr` layer accesses selected by `csel` while the engine is `busy`. It then streams any result memory out for checking. It sits between the engine and the bench or SoC fabric.

## Interface
Parameters:
- `DW`, 20: pixel/result word width (20-bit, 4.16 fixed point).
- `AW`, 12: address width.
- `L0_DEPTH`, 4096: words per L0 bank (csel 1, 2).
- `L1_DEPTH`, 1024: words per L1 bank (csel 3, 4).
- `L2_DEPTH`, 2048: words in L2 bank (csel 5).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `ld_valid`, in, 1: image word valid.
- `ld_data`, in, DW: image word, raster order, address auto-increments from 0.
- `ld_ready`, out, 1: high in LOAD state only.
- `ready`, out, 1: engine start request.
- `busy`, in, 1: engine busy.
- `iaddr`, in, AW: image read address.
- `idata`, out, DW: image word at `iaddr`, combinational.
- `cwr`, in, 1: layer write strobe.
- `caddr_wr`, in, AW: layer write address.
- `cdata_wr`, in, DW: layer write data.
- `crd`, in, 1: layer read strobe.
- `caddr_rd`, in, AW: layer read address.
- `cdata_rd`, out, DW: layer read data, combinational.
- `csel`, in, 3: bank select; 1–5 valid, 0/6/7 = none.
- `dump_start`, in, 1: begin dump of bank `dump_sel`; honoured in DONE only.
- `dump_sel`, in, 3: bank to dump, 1–5.
- `dump_valid`, out, 1: dump word valid.
- `dump_data`, out, DW: dump word.
- `dump_last`, out, 1: final word of the dump.
- `dump_ready`, in, 1: dump sink accepts.
- `done`, out, 1: high in DONE state.
- `err_cnt`, out, 8: illegal access count, saturating at 255.

## Operation
- FSM states: LOAD, START, RUN, DONE, DUMP. Reset enters LOAD.
- **LOAD**
  - Each cycle with `ld_valid` high writes `ld_data` to `img[ld_ptr]` and increments `ld_ptr`.
  - On the write of address 4095, go to START.
- **START**
  - `ready` = 1.
  - Go to RUN on the first cycle `busy` is sampled high.
- **RUN**
  - `ready` = 0.
  - Go to DONE on the first cycle `busy` is sampled low.
- **DONE**
  - `done` = 1.
  - `dump_start` with `dump_sel` in 1..5 → DUMP; `dump_ptr` = 0.
  - `dump_start` with an invalid `dump_sel` is ignored and increments `err_cnt`.
- **DUMP**
  - `dump_valid` = 1 and `dump_data` = `bank[dump_sel_q][dump_ptr]`.
  - `dump_ptr` advances when `dump_valid && dump_ready`.
  - `dump_last` is high on word depth−1; its accept returns the FSM to DONE.
  - `dump_sel` is latched at start.
- Image port, in all states: `idata` = `img[iaddr]`.
- Layer reads:
  - `cdata_rd` = `bank[csel][caddr_rd]` when `crd` is high, `csel` is valid and `caddr_rd` < bank depth.
  - Otherwise `cdata_rd` = 0.
- Layer writes:
  - At posedge, when `cwr` is high, `csel` is valid and `caddr_wr` < bank depth, write `cdata_wr`.
  - Otherwise the write is dropped and `err_cnt` increments.
  - `crd` with an invalid `csel` or out-of-range address also increments `err_cnt`.
  - Layer writes are accepted in any state except LOAD; a write in LOAD counts as an error.
- Simultaneous `cwr` and `crd` to the same bank and address: `cdata_rd` returns the old data (no bypass). Two errors in one cycle add 2.

## Timing
- Reset values:
  - `ready`, `dump_valid`, `dump_last`, `done`, `err_cnt` = 0; `ld_ready` = 1; `ld_ptr` = 0.
  - Memory contents are not reset.
- Read latency 0: `idata`/`cdata_rd` follow the address in the same cycle. Write latency 1: the data is readable the cycle after the `cwr` edge.
- `ready` rises the cycle after the final load word. A `busy` high seen in the same cycle moves the FSM to RUN next cycle, so `ready` lasts ≥1 cycle.
- Dump throughput: 1 word/cycle with `dump_ready` held high. A depth-N dump takes N accepted cycles; `done` is low throughout.
- `dump_data` stays stable while `dump_valid && !dump_ready`.
- Reset mid-RUN or mid-DUMP: return to LOAD; `ld_ptr` = 0; the stream aborts with no `dump_last`.

## Test plan
- Reset, load 4096 words `img[a] = a`, then drive `iaddr` = 0x041 → `idata` = 0x00041. `ready` rises the cycle after word 4095.
- START with `busy` held low for 5 cycles: `ready` stays 1. `busy` high → next cycle `ready` = 0, state RUN. `busy` low → `done` = 1 next cycle.
- `csel` = 3, `cwr`, `caddr_wr` = 1023, data 0xABCDE; next cycle `crd`, `caddr_rd` = 1023 → `cdata_rd` = 0xABCDE. Same write with `caddr_wr` = 1024 → dropped, `err_cnt` = 1.
- `csel` = 0 with `cwr` and `crd` both high in one cycle → `err_cnt` += 2. `crd` with `csel` = 0 → `cdata_rd` = 0.
- Write bank 5 `[k] = k` for k = 0..2047, then dump 5 with `dump_ready` toggling every cycle → 2048 words in order; `dump_last` only on word 2047; data held while stalled; then `done` = 1.
- Assert `reset` mid-dump → all outputs at reset values, `ld_ready` = 1, and a fresh load starts at address 0.
